ysyx_22040750_mem_arbiter: RTL

//  Shares the single AXI4 memory master port between the icache controller (read only) and the dcache controller (read + write).

---
 rtl/ysyx_22040750_mem_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040750_mem_arbiter.sv
`timescale 1ns/1ps
// Shares one AXI4 memory master between icache (read) and dcache (read + write).
// Tie-break policy: define ARB_RR_EN for round-robin, otherwise dcache has fixed priority.
module ysyx_22040750_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  // icache read master
  input  logic [ADDR_W-1:0]   I_ic_araddr,
  input  logic [7:0]          I_ic_arlen,
  input  logic [2:0]          I_ic_arsize,
  input  logic [1:0]          I_ic_arburst,
  input  logic                I_ic_arvalid,
  output logic                O_ic_arready,
  output logic [DATA_W-1:0]   O_ic_rdata,
  output logic                O_ic_rvalid,
  output logic                O_ic_rlast,
  input  logic                I_ic_rready,
  // dcache read master
  input  logic [ADDR_W-1:0]   I_dc_araddr,
  input  logic [7:0]          I_dc_arlen,
  input  logic [2:0]          I_dc_arsize,
  input  logic [1:0]          I_dc_arburst,
  input  logic                I_dc_arvalid,
  output logic                O_dc_arready,
  output logic [DATA_W-1:0]   O_dc_rdata,
  output logic                O_dc_rvalid,
  output logic                O_dc_rlast,
  input  logic                I_dc_rready,
  // dcache write master
  input  logic [ADDR_W-1:0]   I_dc_awaddr,
  input  logic [7:0]          I_dc_awlen,
  input  logic [2:0]          I_dc_awsize,
  input  logic [1:0]          I_dc_awburst,
  input  logic                I_dc_awvalid,
  input  logic [DATA_W-1:0]   I_dc_wdata,
  input  logic [DATA_W/8-1:0] I_dc_wstrb,
  input  logic                I_dc_wlast,
  input  logic                I_dc_wvalid,
  input  logic                I_dc_bready,
  output logic                O_dc_awready,
  output logic                O_dc_wready,
  output logic                O_dc_bvalid,
  // memory AR / R
  output logic [ADDR_W-1:0]   O_mem_araddr,
  output logic [7:0]          O_mem_arlen,
  output logic [2:0]          O_mem_arsize,
  output logic [1:0]          O_mem_arburst,
  output logic                O_mem_arvalid,
  input  logic                I_mem_arready,
  input  logic [DATA_W-1:0]   I_mem_rdata,
  input  logic                I_mem_rvalid,
  input  logic                I_mem_rlast,
  output logic                O_mem_rready,
  // memory AW / W / B
  output logic [ADDR_W-1:0]   O_mem_awaddr,
  output logic [7:0]          O_mem_awlen,
  output logic [2:0]          O_mem_awsize,
  output logic [1:0]          O_mem_awburst,
  output logic                O_mem_awvalid,
  output logic [DATA_W-1:0]   O_mem_wdata,
  output logic [DATA_W/8-1:0] O_mem_wstrb,
  output logic                O_mem_wlast,
  output logic                O_mem_wvalid,
  input  logic                I_mem_awready,
  input  logic                I_mem_wready,
  input  logic                I_mem_bvalid,
  output logic                O_mem_bready
);

  typedef enum logic [2:0] {S_IDLE, S_AR_IC, S_AR_DC, S_R_IC, S_R_DC} state_t;

  state_t r_state, w_state_nxt;
  logic   r_wr_busy;
  logic   r_last_dc;
  logic   w_last_dc_nxt;
  logic   w_aw_hs, w_b_hs, w_tie_ic;

  assign w_aw_hs = I_dc_awvalid & I_mem_awready;
  assign w_b_hs  = I_mem_bvalid & I_dc_bready;

`ifdef ARB_RR_EN
  assign w_tie_ic = r_last_dc;
`else
  assign w_tie_ic = 1'b0;
`endif

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      r_state   <= S_IDLE;
      r_wr_busy <= 1'b0;
      r_last_dc <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_last_dc <= w_last_dc_nxt;
      // a new AW accepted alongside the old B keeps the write window open
      if (w_aw_hs)
        r_wr_busy <= 1'b1;
      else if (w_b_hs)
        r_wr_busy <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_last_dc_nxt = r_last_dc;
    O_mem_araddr  = '0;
    O_mem_arlen   = '0;
    O_mem_arsize  = '0;
    O_mem_arburst = '0;
    O_mem_arvalid = 1'b0;
    O_ic_arready  = 1'b0;
    O_dc_arready  = 1'b0;
    O_ic_rdata    = '0;
    O_ic_rvalid   = 1'b0;
    O_ic_rlast    = 1'b0;
    O_dc_rdata    = '0;
    O_dc_rvalid   = 1'b0;
    O_dc_rlast    = 1'b0;
    O_mem_rready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_wr_busy && !I_dc_awvalid) begin
          if (I_ic_arvalid && I_dc_arvalid)
            w_state_nxt = w_tie_ic ? S_AR_IC : S_AR_DC;
          else if (I_ic_arvalid)
            w_state_nxt = S_AR_IC;
          else if (I_dc_arvalid)
            w_state_nxt = S_AR_DC;
        end
      end
      S_AR_IC: begin
        O_mem_araddr  = I_ic_araddr;
        O_mem_arlen   = I_ic_arlen;
        O_mem_arsize  = I_ic_arsize;
        O_mem_arburst = I_ic_arburst;
        O_mem_arvalid = 1'b1;
        O_ic_arready  = I_mem_arready;
        if (I_mem_arready) begin
          w_state_nxt   = S_R_IC;
          w_last_dc_nxt = 1'b0;
        end
      end
      S_AR_DC: begin
        O_mem_araddr  = I_dc_araddr;
        O_mem_arlen   = I_dc_arlen;
        O_mem_arsize  = I_dc_arsize;
        O_mem_arburst = I_dc_arburst;
        O_mem_arvalid = 1'b1;
        O_dc_arready  = I_mem_arready;
        if (I_mem_arready) begin
          w_state_nxt   = S_R_DC;
          w_last_dc_nxt = 1'b1;
        end
      end
      S_R_IC: begin
        O_ic_rdata   = I_mem_rdata;
        O_ic_rvalid  = I_mem_rvalid;
        O_ic_rlast   = I_mem_rlast;
        O_mem_rready = I_ic_rready;
        if (I_mem_rvalid && I_ic_rready && I_mem_rlast)
          w_state_nxt = S_IDLE;
      end
      S_R_DC: begin
        O_dc_rdata   = I_mem_rdata;
        O_dc_rvalid  = I_mem_rvalid;
        O_dc_rlast   = I_mem_rlast;
        O_mem_rready = I_dc_rready;
        if (I_mem_rvalid && I_dc_rready && I_mem_rlast)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // write channels are never arbitrated
  assign O_mem_awaddr  = I_dc_awaddr;
  assign O_mem_awlen   = I_dc_awlen;
  assign O_mem_awsize  = I_dc_awsize;
  assign O_mem_awburst = I_dc_awburst;
  assign O_mem_awvalid = I_dc_awvalid;
  assign O_mem_wdata   = I_dc_wdata;
  assign O_mem_wstrb   = I_dc_wstrb;
  assign O_mem_wlast   = I_dc_wlast;
  assign O_mem_wvalid  = I_dc_wvalid;
  assign O_dc_awready  = I_mem_awready;
  assign O_dc_wready   = I_mem_wready;
  assign O_dc_bvalid   = I_mem_bvalid;
  assign O_mem_bready  = I_dc_bready;

endmodule
